atanh_sar_4bit_inv: RTL and testbench

This block is the inverse companion to the 4-bit tanh activation circuits. Given a 4-bit tanh output code, it finds the 4-bit input code that produces it. It runs a 4-step successive-approximation (binary) search against a parameterised forward tanh table, with valid/ready handshakes on both sides. It is used for activation-library characterisation and for inverse-mapping stages that sit after a tanh unit.

---
 rtl/atanh_sar_4bit_inv.sv | 94 +++++++++
 tb/tb_atanh_sar_4bit_inv.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/atanh_sar_4bit_inv.sv
// Inverse 4-bit tanh: successive-approximation search over a forward table.
// Returns the smallest x with f(x) >= y (15 when none exists), one bit per cycle.
module atanh_sar_4bit_inv #(
  parameter logic [63:0] F_TABLE = 64'hFFFF_FFFE_EEDB_A740
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_x,
  output logic       out_exact
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] y_reg;
  logic [3:0] r;
  logic [1:0] b;

  logic [3:0] t;
  logic [3:0] t_m1;
  logic [3:0] f_t_m1;
  logic [3:0] r_next;
  logic [3:0] f_r_next;

  function automatic logic [3:0] f_lookup(input logic [3:0] x);
    f_lookup = F_TABLE[{x, 2'b00} +: 4];
  endfunction

  // Trial value sets the current bit; keep it when f just below it still misses y.
  always_comb begin
    t        = r | (4'd1 << b);
    t_m1     = t - 4'd1;
    f_t_m1   = f_lookup(t_m1);
    r_next   = (f_t_m1 < y_reg) ? t : r;
    f_r_next = f_lookup(r_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y_reg     <= '0;
      r         <= '0;
      b         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_exact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            y_reg    <= in_y;
            r        <= '0;
            b        <= 2'd3;
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          r <= r_next;
          b <= b - 2'd1;
          if (b == 2'd0) begin
            out_x     <= r_next;
            out_exact <= (f_r_next == y_reg);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atanh_sar_4bit_inv.sv
// Bench for atanh_sar_4bit_inv: default-table and custom-table instances checked
// against constant vectors and a linear-search reference model.
module tb_atanh_sar_4bit_inv;

  localparam logic [63:0] TBL_D = 64'hFFFF_FFFE_EEDB_A740;
  localparam logic [63:0] TBL_C = 64'hEEEE_EEEE_EEEE_EEEE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv_d, iv_c;
  logic [3:0] in_y;
  logic       out_ready;
  logic       ir_d, ir_c, ov_d, ov_c, ex_d, ex_c;
  logic [3:0] ox_d, ox_c;

  int sel;
  logic       cur_ready, cur_valid, cur_ex;
  logic [3:0] cur_x;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
    logic       ex;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  atanh_sar_4bit_inv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_d), .in_ready(ir_d), .in_y(in_y),
    .out_valid(ov_d), .out_ready(out_ready), .out_x(ox_d), .out_exact(ex_d)
  );

  atanh_sar_4bit_inv #(.F_TABLE(TBL_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .in_y(in_y),
    .out_valid(ov_c), .out_ready(out_ready), .out_x(ox_c), .out_exact(ex_c)
  );

  always_comb begin
    cur_ready = (sel == 0) ? ir_d : ir_c;
    cur_valid = (sel == 0) ? ov_d : ov_c;
    cur_x     = (sel == 0) ? ox_d : ox_c;
    cur_ex    = (sel == 0) ? ex_d : ex_c;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan the table for the first entry reaching y.
  task automatic model(input logic [63:0] tbl, input logic [3:0] y,
                       output logic [3:0] x, output logic ex);
    logic [63:0] v;
    x = 4'd15;
    ex = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      v = tbl >> (4 * i);
      if (v[3:0] >= y) begin
        x = 4'(i);
        ex = (v[3:0] == y);
      end
    end
  endtask

  task automatic accept(input logic [3:0] y);
    int n = 0;
    @(negedge clk);
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", int'(cur_ready), 1);
    in_y = y;
    if (sel == 0) iv_d = 1'b1; else iv_c = 1'b1;
    @(posedge clk);
    #1;
    iv_d = 1'b0;
    iv_c = 1'b0;
    chk("busy_after_accept", int'(cur_ready), 0);
  endtask

  task automatic wait_valid(input bit scramble, output int lat);
    lat = 0;
    while (!cur_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble) in_y = 4'($urandom);
      if (!cur_valid) chk("ready_low_in_search", int'(cur_ready), 0);
    end
    chk("valid_seen", int'(cur_valid), 1);
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
    chk("ready_after_consume", int'(cur_ready), 1);
    chk("valid_after_consume", int'(cur_valid), 0);
  endtask

  task automatic run(input logic [3:0] y, input logic [3:0] ex_x, input logic ex_e,
                     input int hold, input bit scramble);
    int lat;
    out_ready = (hold == 0);
    accept(y);
    wait_valid(scramble, lat);
    chk("latency", lat, 4);
    chk("out_x", int'(cur_x), int'(ex_x));
    chk("out_exact", int'(cur_ex), int'(ex_e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(cur_valid), 1);
      chk("hold_x", int'(cur_x), int'(ex_x));
    end
    out_ready = 1'b1;
    consume();
  endtask

  initial begin
    logic [63:0] xs;
    logic [15:0] exm;
    logic [3:0]  y, mx;
    logic        me;
    int          lat;

    xs  = 64'h9655_4333_2221_1110;
    exm = 16'hEC91;
    for (int i = 0; i < 16; i++) begin
      vecs[i].y  = 4'(i);
      vecs[i].x  = 4'(xs >> (4 * i));
      vecs[i].ex = exm[i];
    end

    sel = 0;
    rst_n = 1'b0;
    iv_d = 1'b0;
    iv_c = 1'b0;
    in_y = '0;
    out_ready = 1'b1;
    #22;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(ir_d), 1);
    chk("rst_out_valid", int'(ov_d), 0);
    chk("rst_out_x", int'(ox_d), 0);
    chk("rst_out_exact", int'(ex_d), 0);

    for (int i = 0; i < 16; i++) run(vecs[i].y, vecs[i].x, vecs[i].ex, 0, 0);

    run(4'd12, 4'd5, 1'b0, 0, 0);

    // Backpressure with ignored requests while the result waits.
    out_ready = 1'b0;
    accept(4'd15);
    wait_valid(0, lat);
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      in_y = 4'($urandom);
      iv_d = h[0];
      chk("bp_valid", int'(ov_d), 1);
      chk("bp_x", int'(ox_d), 9);
      chk("bp_exact", int'(ex_d), 1);
      chk("bp_ready", int'(ir_d), 0);
    end
    @(negedge clk);
    iv_d = 1'b0;
    out_ready = 1'b1;
    consume();

    // Reset two cycles into a search.
    accept(4'd14);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(ov_d), 0);
    chk("mid_rst_x", int'(ox_d), 0);
    chk("mid_rst_exact", int'(ex_d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", int'(ir_d), 1);
    run(4'd1, 4'd1, 1'b0, 0, 0);

    run(4'd7, 4'd2, 1'b1, 0, 1);

    sel = 1;
    run(4'd15, 4'd15, 1'b0, 0, 0);
    run(4'd3, 4'd0, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      y = 4'($urandom);
      model(TBL_C, y, mx, me);
      run(y, mx, me, int'($urandom_range(0, 2)), 0);
    end

    sel = 0;
    for (int k = 0; k < 30; k++) begin
      y = 4'($urandom);
      model(TBL_D, y, mx, me);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(y, mx, me, int'($urandom_range(0, 3)), k[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
